// File: rtl/transposer_buf_resp.sv
// Buffer-side responder: fixed-latency read pipeline with write-first forwarding,
// write absorption into a local array, and access counters plus a sticky address-error flag.
module transposer_buf_resp #(
   parameter int unsigned AW     = 16,
   parameter int unsigned BUFFD  = 64,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 init_pulse,
   input  logic [AW-1:0]        raddr,
   input  logic                 raddr_vld,
   output logic [BUFFD*8-1:0]   rdata,
   output logic                 rdata_vld,
   input  logic [AW-1:0]        waddr,
   input  logic [BUFFD*8-1:0]   wdata,
   input  logic                 wdata_vld,
   output logic [AW-1:0]        rd_cnt,
   output logic [AW-1:0]        wr_cnt,
   output logic                 addr_err
);

   localparam int unsigned DW = BUFFD * 8;
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

   logic [DW-1:0]     mem_q [DEPTH];

   logic              rd_ok_c;
   logic              wr_ok_c;
   logic              fwd_c;
   logic [IW-1:0]     ridx_c;
   logic [IW-1:0]     widx_c;
   logic [DW-1:0]     rd_word_c;

   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] vld_d;
   logic [DW-1:0]     dat_q [RD_LAT];
   logic [DW-1:0]     dat_d [RD_LAT];

   logic [AW-1:0]     rd_cnt_q;
   logic [AW-1:0]     rd_cnt_d;
   logic [AW-1:0]     wr_cnt_q;
   logic [AW-1:0]     wr_cnt_d;
   logic              addr_err_q;
   logic              addr_err_d;

   // Range check uses the full address; one extra bit lets DEPTH == 2**AW compare cleanly.
   always_comb begin
      rd_ok_c = ({1'b0, raddr} < DEPTH_LIM);
      wr_ok_c = ({1'b0, waddr} < DEPTH_LIM);
      ridx_c  = raddr[IW-1:0];
      widx_c  = waddr[IW-1:0];
      fwd_c   = wdata_vld && wr_ok_c && (waddr == raddr);
   end

   // Write-first read port: a same-cycle write to the read address wins over the array.
   always_comb begin
      rd_word_c = '0;
      if (rd_ok_c) begin
         if (fwd_c) begin
            rd_word_c = wdata;
         end else begin
            rd_word_c = mem_q[ridx_c];
         end
      end
   end

   // Storage array is intentionally not reset; contents survive reset_n.
   always_ff @(posedge clk) begin
      if (wdata_vld && wr_ok_c) begin
         mem_q[widx_c] <= wdata;
      end
   end

   always_comb begin
      vld_d    = '0;
      vld_d[0] = raddr_vld;
      dat_d[0] = rd_word_c;
      for (int s = 1; s < RD_LAT; s++) begin
         vld_d[s] = vld_q[s-1];
         dat_d[s] = dat_q[s-1];
      end
   end

   // Stage data only moves with a valid so the final stage holds the last returned word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            dat_q[s] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int s = 0; s < RD_LAT; s++) begin
            if (vld_d[s]) begin
               dat_q[s] <= dat_d[s];
            end
         end
      end
   end

   // init_pulse clears first, then same-cycle accesses and errors still land.
   always_comb begin
      rd_cnt_d   = (init_pulse ? '0 : rd_cnt_q) + AW'(raddr_vld);
      wr_cnt_d   = (init_pulse ? '0 : wr_cnt_q) + AW'(wdata_vld);
      addr_err_d = (addr_err_q & ~init_pulse)
                 | (raddr_vld & ~rd_ok_c)
                 | (wdata_vld & ~wr_ok_c);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         addr_err_q <= 1'b0;
      end else begin
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign rdata     = dat_q[RD_LAT-1];
   assign rdata_vld = vld_q[RD_LAT-1];
   assign rd_cnt    = rd_cnt_q;
   assign wr_cnt    = wr_cnt_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_transposer_buf_resp.sv
// Bench for transposer_buf_resp: directed vector table, reset/streaming sequences,
// and randomized traffic against a queue-based response model.
module tb_transposer_buf_resp;

   localparam int unsigned AW     = 8;
   localparam int unsigned BUFFD  = 4;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned RD_LAT = 3;
   localparam int unsigned DW     = BUFFD * 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              init_pulse = 1'b0;
   logic [AW-1:0]     raddr = '0;
   logic              raddr_vld = 1'b0;
   logic [DW-1:0]     rdata;
   logic              rdata_vld;
   logic [AW-1:0]     waddr = '0;
   logic [DW-1:0]     wdata = '0;
   logic              wdata_vld = 1'b0;
   logic [AW-1:0]     rd_cnt;
   logic [AW-1:0]     wr_cnt;
   logic              addr_err;

   transposer_buf_resp #(
      .AW(AW), .BUFFD(BUFFD), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .init_pulse(init_pulse),
      .raddr(raddr), .raddr_vld(raddr_vld),
      .rdata(rdata), .rdata_vld(rdata_vld),
      .waddr(waddr), .wdata(wdata), .wdata_vld(wdata_vld),
      .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: memory image, pending responses with due cycle, counters.
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      bit            known;
   } rsp_t;

   rsp_t          expq[$];
   logic [DW-1:0] mem_m   [DEPTH];
   bit            known_m [DEPTH];
   logic [DW-1:0] last_m  = '0;
   bit            last_known = 1'b1;
   bit            vld_m   = 1'b0;
   logic [AW-1:0] rd_m    = '0;
   logic [AW-1:0] wr_m    = '0;
   bit            err_m   = 1'b0;

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   task automatic step(input bit rv, input logic [AW-1:0] ra, input bit wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit ini);
      rsp_t r;
      raddr_vld = rv; raddr = ra; wdata_vld = wv; waddr = wa; wdata = wd; init_pulse = ini;
      if (rv) begin
         r.due = cyc + int'(RD_LAT);
         r.known = 1'b1;
         r.data = '0;
         if (int'(ra) < int'(DEPTH)) begin
            if (wv && wa == ra) begin
               r.data = wd;
            end else begin
               r.data  = mem_m[int'(ra)];
               r.known = known_m[int'(ra)];
            end
         end
         expq.push_back(r);
      end
      if (wv && int'(wa) < int'(DEPTH)) begin
         mem_m[int'(wa)]   = wd;
         known_m[int'(wa)] = 1'b1;
      end
      rd_m  = (ini ? AW'(0) : rd_m) + AW'(rv);
      wr_m  = (ini ? AW'(0) : wr_m) + AW'(wv);
      err_m = (err_m && !ini) || (rv && int'(ra) >= int'(DEPTH)) || (wv && int'(wa) >= int'(DEPTH));
      @(posedge clk);
      #1;
      cyc++;
      vld_m = (expq.size() > 0) && (expq[0].due == cyc);
      if (vld_m) begin
         r = expq.pop_front();
         last_m = r.data;
         last_known = r.known;
      end
      chk("rdata_vld", DW'(rdata_vld), DW'(vld_m));
      if (last_known) chk("rdata", rdata, last_m);
      chk("rd_cnt", DW'(rd_cnt), DW'(rd_m));
      chk("wr_cnt", DW'(wr_cnt), DW'(wr_m));
      chk("addr_err", DW'(addr_err), DW'(err_m));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      raddr_vld = 1'b0; wdata_vld = 1'b0; init_pulse = 1'b0;
      expq.delete();
      last_m = '0; last_known = 1'b1; rd_m = '0; wr_m = '0; err_m = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         chk("rst_rdata_vld", DW'(rdata_vld), '0);
         chk("rst_rdata", rdata, '0);
         chk("rst_rd_cnt", DW'(rd_cnt), '0);
         chk("rst_wr_cnt", DW'(wr_cnt), '0);
         chk("rst_addr_err", DW'(addr_err), '0);
      end
      reset_n = 1'b1;
   endtask

   typedef struct {
      bit            rv;
      logic [AW-1:0] ra;
      bit            wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      bit            ini;
      bit            ev;
      logic [DW-1:0] ed;
      logic [AW-1:0] erd;
      logic [AW-1:0] ewr;
      bit            ee;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];

   initial begin
      int            vcnt;
      int            first_v;
      int            last_v;
      int            waited;
      logic [DW-1:0] got;
      logic [AW-1:0] ra_r;
      logic [AW-1:0] wa_r;

      for (int i = 0; i < int'(DEPTH); i++) known_m[i] = 1'b0;

      //          rv ra    wv wa   wd            ini ev ed            erd ewr ee
      tbl[0]  = '{0, 8'd0, 1, 8'd3,  32'hA5A5A5A5, 0, 0, 32'h0,        0, 1, 0};
      tbl[1]  = '{0, 8'd0, 1, 8'd7,  32'hA5A5A5A5, 0, 0, 32'h0,        0, 2, 0};
      tbl[2]  = '{0, 8'd0, 1, 8'd63, 32'hA5A5A5A5, 0, 0, 32'h0,        0, 3, 0};
      tbl[3]  = '{1, 8'd3, 0, 8'd0,  32'h0,        0, 0, 32'h0,        1, 3, 0};
      tbl[4]  = '{1, 8'd7, 0, 8'd0,  32'h0,        0, 0, 32'h0,        2, 3, 0};
      tbl[5]  = '{1, 8'd63,0, 8'd0,  32'h0,        0, 1, 32'hA5A5A5A5, 3, 3, 0};
      tbl[6]  = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 1, 32'hA5A5A5A5, 3, 3, 0};
      tbl[7]  = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 1, 32'hA5A5A5A5, 3, 3, 0};
      tbl[8]  = '{0, 8'd0, 1, 8'd5,  32'h11111111, 0, 0, 32'hA5A5A5A5, 3, 4, 0};
      tbl[9]  = '{1, 8'd5, 1, 8'd5,  32'h22222222, 0, 0, 32'hA5A5A5A5, 4, 5, 0};
      tbl[10] = '{0, 8'd0, 1, 8'd1,  32'h01010101, 0, 0, 32'hA5A5A5A5, 4, 6, 0};
      tbl[11] = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 1, 32'h22222222, 4, 6, 0};
      tbl[12] = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 0, 32'h22222222, 4, 6, 0};
      tbl[13] = '{1, 8'd64,0, 8'd0,  32'h0,        0, 0, 32'h22222222, 5, 6, 1};
      tbl[14] = '{0, 8'd0, 1, 8'd65, 32'hDEADBEEF, 0, 0, 32'h22222222, 5, 7, 1};
      tbl[15] = '{1, 8'd1, 0, 8'd0,  32'h0,        0, 1, 32'h00000000, 6, 7, 1};
      tbl[16] = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 0, 32'h00000000, 6, 7, 1};
      tbl[17] = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 1, 32'h01010101, 6, 7, 1};
      tbl[18] = '{1, 8'd3, 0, 8'd0,  32'h0,        1, 0, 32'h01010101, 1, 0, 0};
      tbl[19] = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 0, 32'h01010101, 1, 0, 0};
      tbl[20] = '{0, 8'd0, 1, 8'd70, 32'h12345678, 1, 1, 32'hA5A5A5A5, 0, 1, 1};
      tbl[21] = '{0, 8'd0, 0, 8'd0,  32'h0,        0, 0, 32'hA5A5A5A5, 0, 1, 1};

      // Power-on reset
      do_reset(3);

      // Directed vectors with hand-derived expectations
      for (int i = 0; i < NV; i++) begin
         step(tbl[i].rv, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].ini);
         chk($sformatf("tbl%0d_vld", i), DW'(rdata_vld), DW'(tbl[i].ev));
         chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].ed);
         chk($sformatf("tbl%0d_rd_cnt", i), DW'(rd_cnt), DW'(tbl[i].erd));
         chk($sformatf("tbl%0d_wr_cnt", i), DW'(wr_cnt), DW'(tbl[i].ewr));
         chk($sformatf("tbl%0d_err", i), DW'(addr_err), DW'(tbl[i].ee));
      end

      // Reset with two reads in flight: they must vanish, memory must survive
      step(1'b1, 8'd3, 1'b0, '0, '0, 1'b0);
      step(1'b1, 8'd7, 1'b0, '0, '0, 1'b0);
      do_reset(2);
      vcnt = 0;
      for (int i = 0; i < int'(RD_LAT) + 2; i++) begin
         idle(1);
         if (rdata_vld) vcnt++;
      end
      chk("post_reset_vld_count", DW'(vcnt), '0);
      chk("post_reset_rdata", rdata, '0);
      step(1'b1, 8'd3, 1'b0, '0, '0, 1'b0);
      got = '0;
      waited = 0;
      while (!rdata_vld && waited < 8) begin
         idle(1);
         waited++;
      end
      if (rdata_vld) got = rdata;
      chk("post_reset_wait", DW'(waited), DW'(RD_LAT - 1));
      chk("post_reset_data_kept", got, 32'hA5A5A5A5);

      // Pre-fill then stream DEPTH back-to-back reads
      for (int a = 0; a < int'(DEPTH); a++) step(1'b0, '0, 1'b1, AW'(a), DW'($urandom), 1'b0);
      step(1'b0, '0, 1'b0, '0, '0, 1'b1);
      vcnt = 0; first_v = -1; last_v = -1;
      for (int a = 0; a < int'(DEPTH) + int'(RD_LAT) + 2; a++) begin
         if (a < int'(DEPTH)) step(1'b1, AW'(a), 1'b0, '0, '0, 1'b0);
         else idle(1);
         if (rdata_vld) begin
            vcnt++;
            if (first_v < 0) first_v = a;
            last_v = a;
         end
      end
      chk("stream_vld_count", DW'(vcnt), DW'(DEPTH));
      chk("stream_contiguous", DW'(last_v - first_v + 1), DW'(DEPTH));
      chk("stream_rd_cnt", DW'(rd_cnt), DW'(DEPTH));

      // Randomized mixed traffic, including out-of-range and same-address collisions
      for (int i = 0; i < 400; i++) begin
         ra_r = AW'($urandom_range(0, DEPTH + 7));
         wa_r = ($urandom_range(0, 3) == 0) ? ra_r : AW'($urandom_range(0, DEPTH + 7));
         step(1'($urandom), ra_r, 1'($urandom), wa_r, DW'($urandom), ($urandom_range(0, 15) == 0));
      end
      idle(int'(RD_LAT) + 1);
      chk("drain_queue_empty", DW'(expq.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/transposer_buf_resp.md
# transposer_buf_resp

Buffer-side responder for the transposer's memory interface. It accepts read addresses and returns read data after a fixed pipeline latency. It also absorbs write beats into a local array and keeps access counters and an address-error flag for the bench and for top-level status. It sits between the transposer's raddr/rdata/waddr/wdata ports and the local feature buffer, and replaces the behavioural memory model in RTL and gate-level sims.

## Interface
Parameters:
- AW, 16, address and counter width
- BUFFD, 64, bytes per buffer word; data width is BUFFD*8
- DEPTH, 1024, number of buffer words; power of two, DEPTH <= 2**AW
- RD_LAT, 2, read latency in cycles, legal range 1..4

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- init_pulse  input  1  one-cycle pulse; clears counters and error flag, memory contents untouched
- raddr  input  AW  read word address
- raddr_vld  input  1  read request strobe, at most one per cycle, no backpressure
- rdata  output  BUFFD*8  read data
- rdata_vld  output  1  read data valid
- waddr  input  AW  write word address
- wdata  input  BUFFD*8  write data
- wdata_vld  input  1  write strobe, at most one per cycle
- rd_cnt  output  AW  accepted read requests since last init_pulse/reset
- wr_cnt  output  AW  accepted write beats since last init_pulse/reset
- addr_err  output  1  sticky: some access had address >= DEPTH

## Operation
- Storage: DEPTH x (BUFFD*8) array. It is not reset; its contents are undefined until written.
- Address check: an access is in range when the full AW-bit address < DEPTH. The array is indexed by the low log2(DEPTH) bits of in-range addresses only.
- Write: wdata_vld high with waddr in range stores wdata at the rising edge. An out-of-range write is dropped and sets addr_err.
- Read: raddr_vld high in cycle N samples the array in cycle N.
  - A same-cycle write to the same in-range address is forwarded, so the read returns the new wdata (write-first).
  - An out-of-range read returns all zeros, still produces rdata_vld, and sets addr_err.
- Read pipeline: RD_LAT stages, each holding a valid bit and data. Requests issue back-to-back every cycle and come out in order. Stage data updates only when its valid is set. rdata holds the last returned value while rdata_vld is low.
- Counters: rd_cnt increments on every raddr_vld and wr_cnt on every wdata_vld, whether in range or not. Both wrap modulo 2**AW.
- init_pulse: counters go to 0 and addr_err to 0. Accesses in the same cycle still count, so a counter reads 1 the next cycle. An error in the same cycle leaves addr_err set. In-flight reads are not affected.
- There is no state machine beyond the pipeline. The block is always ready.

## Timing
- Reset values: rdata = 0, rdata_vld = 0, rd_cnt = 0, wr_cnt = 0, addr_err = 0, all pipeline valids = 0.
- Read latency: raddr_vld at edge N gives rdata_vld/rdata valid after edge N+RD_LAT. With RD_LAT = 1, data is valid in the cycle after the request.
- Throughput: one read and one write per cycle, both at once allowed.
- Read after write: a write at edge N is visible to a read issued in cycle N (forwarding) and in any later cycle.
- A write issued after a read but before that read's data returns does not change the returned data.
- Reset mid-operation: asserting reset_n low drops in-flight reads; no rdata_vld is emitted for them after release. Memory contents survive reset.
- Counters and addr_err are registered: each updates one edge after the triggering access.

## Test plan
- Write-then-read: write 0xA5 repeated at addr 3, 7, DEPTH-1. Read the same addresses back-to-back. Required: rdata_vld pulses exactly RD_LAT cycles after each request with matching data, rd_cnt = 3, wr_cnt = 3.
- Same-cycle forwarding: addr 5 holds 0x11.., then one cycle has write 0x22.. to addr 5 and read addr 5. Required: returned data = 0x22...
- Out of range: read addr DEPTH and write addr DEPTH+1. Required: read returns zeros with rdata_vld, the write is dropped (addr 1 unchanged), addr_err = 1 until init_pulse; rd_cnt and wr_cnt both increment.
- Streaming: 64 consecutive reads (raddr_vld held high) over a pre-filled array. Required: 64 contiguous rdata_vld cycles in order, rd_cnt = 64.
- Init and reset: init_pulse in the same cycle as a read, giving rd_cnt = 1 afterwards. Then pull reset_n low with 2 reads in flight. Required: no rdata_vld after release, all outputs 0, previously written data still readable.
